// File: rtl/ps2out.sv
// ps2out: PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device over the open-drain clock/data pair.
// The sequence is: hold the clock low (inhibit), pull data low as the start bit
// (request-to-send), release the clock, then shift the bits out on the
// device-generated falling edges. After that it samples the device ACK and
// waits for both lines to return high.
//
// Parameters
//   INHIBIT_CYCLES  cycles the clock line is held low before request-to-send
//   TIMEOUT_CYCLES  max cycles from clock release to ACK/line release
//
// Ports
//   clk         system clock
//   res         synchronous active-high reset
//   data        command byte, captured when a send is accepted
//   send        start strobe, honoured only while busy is low
//   busy        transfer in progress
//   done        one-cycle pulse: byte sent and ACK received
//   error       one-cycle pulse: missing ACK or timeout
//   ps2clk_in   raw PS/2 clock pin (asynchronous)
//   ps2data_in  raw PS/2 data pin (asynchronous)
//   ps2clk_oe   1 = pull PS/2 clock low
//   ps2data_oe  1 = pull PS/2 data low
//
// Build option: define PS2OUT_GLITCH_FILTER_EN to add an 8-cycle stability
// filter on the synchronised clock line. The data line is never filtered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | lines released, waiting for send
// INHIBIT  | clock held low for INHIBIT_CYCLES
// REQ      | clock and data both held low for one cycle (start bit)
// SHIFT    | clock released; one bit driven per device falling edge
// ACK      | stop bit out; sample device ACK on next falling edge
// WAITREL  | ACK seen; wait for clock and data to return high

module ps2out #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);

    // The inhibit and timeout phases never overlap, so they share one timer.
    localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAITREL
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         sh_q, sh_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               data_oe_q, data_oe_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               clk_s1_q, clk_s2_q;
    logic               dat_s1_q, dat_s2_q;
    logic               clk_prev_q;
    logic               clk_lvl;
    logic               clk_fall;

    // Synchronisers reset to 1 (idle bus level) so reset cannot fake an edge.
    always_ff @(posedge clk) begin
        if (res) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2data_in;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2OUT_GLITCH_FILTER_EN
    logic       clk_filt_q;
    logic [2:0] flt_cnt_q;

    // Filtered level follows the synchronised level only after 8 consecutive
    // samples that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (res) begin
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else if (clk_s2_q == clk_filt_q) begin
            flt_cnt_q  <= '0;
        end else if (flt_cnt_q == 3'd7) begin
            clk_filt_q <= clk_s2_q;
            flt_cnt_q  <= '0;
        end else begin
            flt_cnt_q  <= flt_cnt_q + 3'd1;
        end
    end

    assign clk_lvl = clk_filt_q;
`else
    assign clk_lvl = clk_s2_q;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_lvl;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            tmr_q     <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        tmr_d     = tmr_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (send) begin
                    sh_d      = {1'b1, ~^data, data};
                    bit_cnt_d = '0;
                    tmr_d     = TMR_W'(INHIBIT_CYCLES - 1);
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (tmr_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            S_REQ: begin
                tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
                state_d = S_SHIFT;
            end

            S_SHIFT, S_ACK, S_WAITREL: begin
                if (tmr_q == '0) begin
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                    if (state_q == S_SHIFT) begin
                        if (clk_fall) begin
                            // Bit 9 is the stop bit (1), i.e. a release.
                            data_oe_d = ~sh_q[bit_cnt_q];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd9) begin
                                state_d = S_ACK;
                            end
                        end
                    end else if (state_q == S_ACK) begin
                        if (clk_fall) begin
                            if (!dat_s2_q) begin
                                state_d = S_WAITREL;
                            end else begin
                                data_oe_d = 1'b0;
                                error_d   = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end else begin
                        if (clk_lvl && dat_s2_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign ps2clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2data_oe = data_oe_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
